// File: rtl/decode_cycle_pkg.sv
// Shared decode definitions: opcodes, control encodings and the pure decode functions
// used by the ID stage.
package decode_cycle_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IMM_I    = 2'b00,
    IMM_S    = 2'b01,
    IMM_B    = 2'b10,
    IMM_NONE = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef struct packed {
    logic     reg_write;
    imm_src_e imm_src;
    logic     alu_src;
    logic     mem_write;
    logic     result_src;
    logic     branch;
    alu_op_e  alu_op;
  } ctrl_t;

  function automatic ctrl_t main_decode(input logic [6:0] opcode);
    ctrl_t c;
    c = '{reg_write: 1'b0, imm_src: IMM_I, alu_src: 1'b0, mem_write: 1'b0,
          result_src: 1'b0, branch: 1'b0, alu_op: ALUOP_ADD};
    case (opcode)
      OP_LOAD:   c = '{1'b1, IMM_I, 1'b1, 1'b0, 1'b1, 1'b0, ALUOP_ADD};
      OP_STORE:  c = '{1'b0, IMM_S, 1'b1, 1'b1, 1'b0, 1'b0, ALUOP_ADD};
      OP_RTYPE:  c = '{1'b1, IMM_I, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT};
      OP_ITYPE:  c = '{1'b1, IMM_I, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT};
      OP_BRANCH: c = '{1'b0, IMM_B, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_SUB};
      default:   ;
    endcase
    return c;
  endfunction

  // Subtract only for R-type with funct7[5] set; I-type ALU ops always add on funct3=000.
  function automatic alu_ctrl_e alu_decode(input alu_op_e op, input logic [2:0] funct3,
                                           input logic op5, input logic funct7_5);
    alu_ctrl_e a;
    a = ALU_ADD;
    case (op)
      ALUOP_SUB: a = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  a = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  a = ALU_SLT;
          3'b110:  a = ALU_OR;
          3'b111:  a = ALU_AND;
          default: a = ALU_ADD;
        endcase
      end
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

  function automatic logic [31:0] imm_extend(input imm_src_e src, input logic [31:0] instr);
    logic [31:0] imm;
    imm = 32'd0;
    case (src)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_cycle_if.sv
// Bundle of the decode stage's IF/ID, WB and ID/EX signals; master drives the stage inputs.
interface decode_cycle_if;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;

  logic        RegWriteE;
  logic        ALUSrcE;
  logic        MemWriteE;
  logic        ResultSrcE;
  logic        BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic [31:0] Imm_Ext_E;
  logic [4:0]  RD_E;
  logic [4:0]  RS1_E;
  logic [4:0]  RS2_E;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;

  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW,
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, RD_E, RS1_E, RS2_E, PCE, PCPlus4E
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW,
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, RD_E, RS1_E, RS2_E, PCE, PCPlus4E
  );
endinterface

// File: rtl/decode_cycle_regfile.sv
// 32x32 register file: two combinational read ports with WB write-through bypass,
// one synchronous write port, synchronous active-low clear. x0 is hard-wired to zero.
module decode_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);
  logic [31:0] r_regs [0:31];
  logic        w_wr_valid;

  assign w_wr_valid = i_we && (i_wa != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (w_wr_valid) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // Bypass lets an instruction in ID see the value WB is writing this same cycle.
  always_comb begin
    o_rd1 = r_regs[i_rs1];
    o_rd2 = r_regs[i_rs2];
    if (w_wr_valid && (i_wa == i_rs1)) o_rd1 = i_wd;
    if (w_wr_valid && (i_wa == i_rs2)) o_rd2 = i_wd;
    if (i_rs1 == 5'd0) o_rd1 = 32'd0;
    if (i_rs2 == 5'd0) o_rd2 = 32'd0;
  end
endmodule

// File: rtl/decode_cycle.sv
// RV32I-subset decode stage: control/immediate decode, register-file access and the
// ID/EX pipeline register. Reset clears the ID/EX register, inserting a bubble.
module decode_cycle
  import decode_cycle_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  decode_cycle_if.slave bus
);
  ctrl_t       w_ctrl;
  alu_ctrl_e   w_alu_ctrl;
  logic [31:0] w_imm;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;

  logic        r_reg_write;
  logic        r_alu_src;
  logic        r_mem_write;
  logic        r_result_src;
  logic        r_branch;
  logic [2:0]  r_alu_ctrl;
  logic [31:0] r_rd1;
  logic [31:0] r_rd2;
  logic [31:0] r_imm;
  logic [4:0]  r_rd;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus4;

  assign w_ctrl     = main_decode(bus.InstrD[6:0]);
  assign w_alu_ctrl = alu_decode(w_ctrl.alu_op, bus.InstrD[14:12], bus.InstrD[5], bus.InstrD[30]);
  assign w_imm      = imm_extend(w_ctrl.imm_src, bus.InstrD);

  decode_regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .i_rs1 (bus.InstrD[19:15]),
    .i_rs2 (bus.InstrD[24:20]),
    .i_we  (bus.RegWriteW),
    .i_wa  (bus.RDW),
    .i_wd  (bus.ResultW),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_reg_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 1'b0;
      r_branch     <= 1'b0;
      r_alu_ctrl   <= 3'd0;
      r_rd1        <= 32'd0;
      r_rd2        <= 32'd0;
      r_imm        <= 32'd0;
      r_rd         <= 5'd0;
      r_rs1        <= 5'd0;
      r_rs2        <= 5'd0;
      r_pc         <= 32'd0;
      r_pc_plus4   <= 32'd0;
    end else begin
      r_reg_write  <= w_ctrl.reg_write;
      r_alu_src    <= w_ctrl.alu_src;
      r_mem_write  <= w_ctrl.mem_write;
      r_result_src <= w_ctrl.result_src;
      r_branch     <= w_ctrl.branch;
      r_alu_ctrl   <= w_alu_ctrl;
      r_rd1        <= w_rd1;
      r_rd2        <= w_rd2;
      r_imm        <= w_imm;
      r_rd         <= bus.InstrD[11:7];
      r_rs1        <= bus.InstrD[19:15];
      r_rs2        <= bus.InstrD[24:20];
      r_pc         <= bus.PCD;
      r_pc_plus4   <= bus.PCPlus4D;
    end
  end

  assign bus.RegWriteE   = r_reg_write;
  assign bus.ALUSrcE     = r_alu_src;
  assign bus.MemWriteE   = r_mem_write;
  assign bus.ResultSrcE  = r_result_src;
  assign bus.BranchE     = r_branch;
  assign bus.ALUControlE = r_alu_ctrl;
  assign bus.RD1_E       = r_rd1;
  assign bus.RD2_E       = r_rd2;
  assign bus.Imm_Ext_E   = r_imm;
  assign bus.RD_E        = r_rd;
  assign bus.RS1_E       = r_rs1;
  assign bus.RS2_E       = r_rs2;
  assign bus.PCE         = r_pc;
  assign bus.PCPlus4E    = r_pc_plus4;
endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: hand-written reset/bypass/x0 sequences, then a
// table of instructions with hand-computed ID/EX contents.
module tb_decode_cycle;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  decode_cycle_if bus ();

  decode_cycle dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic        asrc;
    logic        mw;
    logic        rsrc;
    logic        br;
    logic [2:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] pc4;
  } out_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    out_t        exp;
  } vec_t;

  vec_t vecs [15];

  function automatic out_t mk(input logic rw, input logic asrc, input logic mw,
                              input logic rsrc, input logic br, input logic [2:0] alu,
                              input logic [31:0] imm, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] rd1, input logic [31:0] rd2);
    out_t o;
    o = '{rw, asrc, mw, rsrc, br, alu, imm, rd, rs1, rs2, rd1, rd2, 32'd0, 32'd0};
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o = '{bus.RegWriteE, bus.ALUSrcE, bus.MemWriteE, bus.ResultSrcE, bus.BranchE,
          bus.ALUControlE, bus.Imm_Ext_E, bus.RD_E, bus.RS1_E, bus.RS2_E,
          bus.RD1_E, bus.RD2_E, bus.PCE, bus.PCPlus4E};
    return o;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check_out(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: ctl=%b alu=%b imm=%h rd=%0d rs1=%0d rs2=%0d rd1=%h rd2=%h",
               name, {act.rw, act.asrc, act.mw, act.rsrc, act.br}, act.alu, act.imm,
               act.rd, act.rs1, act.rs2, act.rd1, act.rd2);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    bus.InstrD    = instr;
    bus.PCD       = pc;
    bus.PCPlus4D  = pc + 32'd4;
    bus.RegWriteW = we;
    bus.RDW       = wa;
    bus.ResultW   = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{"add",      32'h002081B3, mk(1,0,0,0,0,3'b000,32'h00000002, 3, 1, 2,32'h100,32'h200)};
    vecs[1]  = '{"sub",      32'h40208433, mk(1,0,0,0,0,3'b001,32'h00000402, 8, 1, 2,32'h100,32'h200)};
    vecs[2]  = '{"and",      32'h0020F4B3, mk(1,0,0,0,0,3'b010,32'h00000002, 9, 1, 2,32'h100,32'h200)};
    vecs[3]  = '{"or",       32'h0020E533, mk(1,0,0,0,0,3'b011,32'h00000002,10, 1, 2,32'h100,32'h200)};
    vecs[4]  = '{"slt",      32'h0020A5B3, mk(1,0,0,0,0,3'b101,32'h00000002,11, 1, 2,32'h100,32'h200)};
    vecs[5]  = '{"sll",      32'h002091B3, mk(1,0,0,0,0,3'b000,32'h00000002, 3, 1, 2,32'h100,32'h200)};
    vecs[6]  = '{"addi",     32'h00A10293, mk(1,1,0,0,0,3'b000,32'h0000000A, 5, 2,10,32'h200,32'h0)};
    vecs[7]  = '{"addi_neg", 32'hC0010293, mk(1,1,0,0,0,3'b000,32'hFFFFFC00, 5, 2, 0,32'h200,32'h0)};
    vecs[8]  = '{"xori",     32'h0FF14293, mk(1,1,0,0,0,3'b000,32'h000000FF, 5, 2,31,32'h200,32'h0)};
    vecs[9]  = '{"lw",       32'h0040A303, mk(1,1,0,1,0,3'b000,32'h00000004, 6, 1, 4,32'h100,32'h0)};
    vecs[10] = '{"sw",       32'h0070A423, mk(0,1,1,0,0,3'b000,32'h00000008, 8, 1, 7,32'h100,32'h777)};
    vecs[11] = '{"beq",      32'h00208163, mk(0,0,0,0,1,3'b001,32'h00000002, 2, 1, 2,32'h100,32'h200)};
    vecs[12] = '{"beq_neg",  32'hFE208EE3, mk(0,0,0,0,1,3'b001,32'hFFFFFFFC,29, 1, 2,32'h100,32'h200)};
    vecs[13] = '{"illegal",  32'hFFFFFFFF, mk(0,0,0,0,0,3'b000,32'hFFFFFFFF,31,31,31,32'h0,32'h0)};
    vecs[14] = '{"read_x3",  32'h000181B3, mk(1,0,0,0,0,3'b000,32'h00000000, 3, 3, 0,32'hA5A5A5A5,32'h0)};

    // Power-on clear, then seed x3 so the following reset can be seen to clear it.
    rst = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    rst = 1'b1;
    drive(32'h002081B3, 32'h40, 1'b1, 5'd3, 32'h00001111);
    tick();

    // Reset with a simultaneous WB write: outputs clear and x3 must not be written.
    rst = 1'b0;
    drive(32'h002081B3, 32'h44, 1'b1, 5'd3, 32'hDEADBEEF);
    tick();
    check_out("reset_outputs", sample(), '0);
    rst = 1'b1;
    drive(32'h000181B3, 32'h48, 1'b0, 5'd0, 32'h0);
    tick();
    check32("reset_x3_cleared", bus.RD1_E, 32'h0);

    // Seed x1, x2, x7 through WB with NOP instructions.
    drive(32'h0, 32'h50, 1'b1, 5'd1, 32'h100);
    tick();
    drive(32'h0, 32'h54, 1'b1, 5'd2, 32'h200);
    tick();
    drive(32'h0, 32'h58, 1'b1, 5'd7, 32'h777);
    tick();

    // Bypass: add x3,x3,x2 while WB writes x3 in the same cycle.
    drive(32'h002181B3, 32'h60, 1'b1, 5'd3, 32'hA5A5A5A5);
    tick();
    check32("bypass_rd1", bus.RD1_E, 32'hA5A5A5A5);
    check32("bypass_rd2", bus.RD2_E, 32'h200);
    check32("bypass_ctl", {27'd0, bus.RegWriteE, bus.ALUSrcE, bus.ALUControlE}, {27'd0, 5'b10000});
    check32("bypass_rd",  {27'd0, bus.RD_E}, 32'd3);
    check32("bypass_pc",  bus.PCE, 32'h60);
    check32("bypass_pc4", bus.PCPlus4E, 32'h64);

    // Writing x0 must neither bypass nor stick.
    drive(32'h000001B3, 32'h70, 1'b1, 5'd0, 32'hFFFFFFFF);
    tick();
    check32("x0_bypass_rd1", bus.RD1_E, 32'h0);
    check32("x0_bypass_rd2", bus.RD2_E, 32'h0);
    drive(32'h000001B3, 32'h74, 1'b0, 5'd0, 32'h0);
    tick();
    check32("x0_stored_rd1", bus.RD1_E, 32'h0);

    for (int i = 0; i < 15; i++) begin
      out_t e;
      logic [31:0] pc;
      pc = 32'h1000 + 32'(i) * 32'd4;
      e = vecs[i].exp;
      e.pc  = pc;
      e.pc4 = pc + 32'd4;
      drive(vecs[i].instr, pc, 1'b0, 5'd0, 32'h0);
      tick();
      check_out(vecs[i].name, sample(), e);
    end

    // Mid-stream reset acts as a bubble, and the stage resumes right after.
    rst = 1'b0;
    drive(32'h0040A303, 32'h2000, 1'b0, 5'd0, 32'h0);
    tick();
    check_out("midstream_bubble", sample(), '0);
    rst = 1'b1;
    drive(32'h00A10293, 32'h2004, 1'b0, 5'd0, 32'h0);
    tick();
    check32("after_bubble_imm", bus.Imm_Ext_E, 32'h0000000A);
    check32("after_bubble_x2_cleared", bus.RD1_E, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
